// File: rtl/sensor_stream_gen_if.sv
// Sensor-side stream bundle: frame/line valid, pixel data, frame-done pulse, frame count.
// Latency: n/a (wires only); the master drives all members from registers.
// Backpressure: none; a sensor stream cannot be stalled, so the slave must keep up.
interface sensor_stream_gen_if #(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int CHANNEL_NUM      = 4,
   parameter int REG_WD           = 32
) ();
   logic                                  fval;
   logic                                  lval;
   logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] pix_data;
   logic                                  frame_done;
   logic [REG_WD-1:0]                     frame_cnt;

   modport master (output fval, output lval, output pix_data, output frame_done, output frame_cnt);
   modport slave  (input  fval, input  lval, input  pix_data, input  frame_done, input  frame_cnt);
endinterface

// File: rtl/sensor_stream_gen.sv
// Sensor stream generator: fval/lval/pixel frames with programmable geometry, blanking and test patterns.
// Latency: every output is registered; a state decision shows on the outputs one clk_pix later.
// Backpressure: none; free-running source. Optional macro SENSOR_STREAM_GEN_FRAME_TAG_EN tags pixel 0 of each frame.
module sensor_stream_gen #(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int CHANNEL_NUM      = 4,
   parameter int REG_WD           = 32,
   parameter int FVAL_LVAL_GAP    = 3
) (
   input  logic              clk_pix,
   input  logic              reset_pix,
   input  logic              i_gen_en,
   input  logic [REG_WD-1:0] iv_width,
   input  logic [REG_WD-1:0] iv_height,
   input  logic [REG_WD-1:0] iv_h_blank,
   input  logic [REG_WD-1:0] iv_v_blank,
   input  logic [1:0]        iv_pattern_sel,
   sensor_stream_gen_if.master sif
);
   localparam int DW = SENSOR_DAT_WIDTH;
   localparam int CH = CHANNEL_NUM;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HEAD = 3'd1;
   localparam logic [2:0] S_LINE = 3'd2;
   localparam logic [2:0] S_HBLK = 3'd3;
   localparam logic [2:0] S_TAIL = 3'd4;
   localparam logic [2:0] S_VBLK = 3'd5;

   localparam logic [REG_WD-1:0] GAP_M1 = REG_WD'(FVAL_LVAL_GAP - 1);

   logic [2:0]         state, nxt_state;
   logic [REG_WD-1:0]  cnt, nxt_cnt;
   logic [REG_WD-1:0]  line, nxt_line;
   logic [REG_WD-1:0]  w_m1, h_m1, hb_m1, vb_m1;
   logic [1:0]         sel_q;
   logic [15:0]        lfsr;
   logic [REG_WD-1:0]  frame_cnt;
   logic               latch, done_n;
   logic               fval, lval, done;
   logic [DW*CH-1:0]   pix, pix_n;
   logic [DW-1:0]      ch;

   // Zero-length segments behave as length one; store length minus one.
   function automatic logic [REG_WD-1:0] len_m1(input logic [REG_WD-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   // Next-state decision; cnt counts cycles already spent in the current segment.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 1'b1;
      nxt_line  = line;
      latch     = 1'b0;
      done_n    = 1'b0;
      case (state)
         S_IDLE: begin
            nxt_cnt = '0;
            if (i_gen_en) begin
               nxt_state = S_HEAD;
               latch     = 1'b1;
            end
         end
         S_HEAD: if (cnt == GAP_M1) begin
            nxt_state = S_LINE;
            nxt_cnt   = '0;
            nxt_line  = '0;
         end
         S_LINE: if (cnt == w_m1) begin
            nxt_cnt   = '0;
            nxt_state = (line == h_m1) ? S_TAIL : S_HBLK;
         end
         S_HBLK: if (cnt == hb_m1) begin
            nxt_state = S_LINE;
            nxt_cnt   = '0;
            nxt_line  = line + 1'b1;
         end
         S_TAIL: if (cnt == GAP_M1) begin
            nxt_state = S_VBLK;
            nxt_cnt   = '0;
            done_n    = 1'b1;
         end
         S_VBLK: if (cnt == vb_m1) begin
            nxt_cnt = '0;
            if (i_gen_en) begin
               nxt_state = S_HEAD;
               latch     = 1'b1;
            end else begin
               nxt_state = S_IDLE;
            end
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
         end
      endcase
   end

   // Pixel word for the upcoming LINE cycle, built from the next pixel/line index.
   always_comb begin
      pix_n = '0;
      ch    = '0;
      for (int k = 0; k < CH; k++) begin
         case (sel_q)
            2'd0:    ch = DW'(nxt_cnt * REG_WD'(CH) + REG_WD'(k));
            2'd1:    ch = DW'(nxt_line);
            2'd2:    ch = DW'(frame_cnt);
            default: ch = DW'(lfsr) ^ DW'(k);
         endcase
`ifdef SENSOR_STREAM_GEN_FRAME_TAG_EN
         if (nxt_line == '0 && nxt_cnt == '0) ch = DW'(frame_cnt);
`endif
         pix_n[k*DW +: DW] = ch;
      end
   end

   // State, latched frame config, LFSR, frame counter and registered outputs.
   always_ff @(posedge clk_pix) begin
      if (reset_pix) begin
         state     <= S_IDLE;
         cnt       <= '0;
         line      <= '0;
         w_m1      <= '0;
         h_m1      <= '0;
         hb_m1     <= '0;
         vb_m1     <= '0;
         sel_q     <= '0;
         lfsr      <= 16'hACE1;
         frame_cnt <= '0;
         fval      <= 1'b0;
         lval      <= 1'b0;
         pix       <= '0;
         done      <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         line  <= nxt_line;
         if (latch) begin
            w_m1  <= len_m1(iv_width);
            h_m1  <= len_m1(iv_height);
            hb_m1 <= len_m1(iv_h_blank);
            vb_m1 <= len_m1(iv_v_blank);
            sel_q <= iv_pattern_sel;
         end
         if (nxt_state == S_LINE) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         if (done_n) frame_cnt <= frame_cnt + 1'b1;
         fval <= (nxt_state == S_HEAD) || (nxt_state == S_LINE) ||
                 (nxt_state == S_HBLK) || (nxt_state == S_TAIL);
         lval <= (nxt_state == S_LINE);
         pix  <= (nxt_state == S_LINE) ? pix_n : '0;
         done <= done_n;
      end
   end

   assign sif.fval       = fval;
   assign sif.lval       = lval;
   assign sif.pix_data   = pix;
   assign sif.frame_done = done;
   assign sif.frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_sensor_stream_gen.sv
// Bench for sensor_stream_gen: scenario tasks plus a frame-level reference model of the stream.
// Latency: outputs sampled on the falling edge, one cycle after the deciding rising edge.
// Backpressure: none; the model follows the free-running stream cycle by cycle.
module tb_sensor_stream_gen;
   localparam int DW  = 10;
   localparam int CH  = 4;
   localparam int RW  = 32;
   localparam int GAP = 3;
   localparam int NFR = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [RW-1:0] w, h, hb, vb;
   logic [1:0]    sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sensor_stream_gen_if #(.SENSOR_DAT_WIDTH(DW), .CHANNEL_NUM(CH), .REG_WD(RW)) sif ();

   sensor_stream_gen #(.SENSOR_DAT_WIDTH(DW), .CHANNEL_NUM(CH), .REG_WD(RW), .FVAL_LVAL_GAP(GAP)) dut (
      .clk_pix(clk), .reset_pix(rst), .i_gen_en(en),
      .iv_width(w), .iv_height(h), .iv_h_blank(hb), .iv_v_blank(vb),
      .iv_pattern_sel(sel), .sif(sif)
   );

   typedef struct {
      logic          fval;
      logic          lval;
      logic          done;
      logic [DW*CH-1:0] dat;
      logic [RW-1:0] cnt;
   } item_t;

   item_t       exp_q[$];
   logic [15:0] m_lfsr;
   int          m_cnt;
   int          fstart[NFR];

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic b;
      b = l[0] ^ l[2] ^ l[3] ^ l[5];
      return {b, l[15:1]};
   endfunction

   // Expand one frame into its expected cycle sequence from the geometry rules.
   task automatic model_frame(input int fw, input int fh, input int fhb, input int fvb, input int fsel);
      item_t it;
      int w1, h1, hb1, vb1, v;
      w1  = (fw  == 0) ? 1 : fw;
      h1  = (fh  == 0) ? 1 : fh;
      hb1 = (fhb == 0) ? 1 : fhb;
      vb1 = (fvb == 0) ? 1 : fvb;
      it = '{fval: 1'b1, lval: 1'b0, done: 1'b0, dat: '0, cnt: RW'(m_cnt)};
      for (int g = 0; g < GAP; g++) exp_q.push_back(it);
      for (int ln = 0; ln < h1; ln++) begin
         for (int p = 0; p < w1; p++) begin
            it = '{fval: 1'b1, lval: 1'b1, done: 1'b0, dat: '0, cnt: RW'(m_cnt)};
            for (int k = 0; k < CH; k++) begin
               case (fsel)
                  0:       v = (p * CH + k) % (1 << DW);
                  1:       v = ln % (1 << DW);
                  2:       v = m_cnt % (1 << DW);
                  default: v = (int'(m_lfsr) % (1 << DW)) ^ k;
               endcase
`ifdef SENSOR_STREAM_GEN_FRAME_TAG_EN
               if (ln == 0 && p == 0) v = m_cnt % (1 << DW);
`endif
               it.dat[k*DW +: DW] = v[DW-1:0];
            end
            exp_q.push_back(it);
            m_lfsr = lfsr_next(m_lfsr);
         end
         if (ln < h1 - 1) begin
            it = '{fval: 1'b1, lval: 1'b0, done: 1'b0, dat: '0, cnt: RW'(m_cnt)};
            for (int b = 0; b < hb1; b++) exp_q.push_back(it);
         end
      end
      it = '{fval: 1'b1, lval: 1'b0, done: 1'b0, dat: '0, cnt: RW'(m_cnt)};
      for (int g = 0; g < GAP; g++) exp_q.push_back(it);
      m_cnt++;
      for (int b = 0; b < vb1; b++) begin
         it = '{fval: 1'b0, lval: 1'b0, done: (b == 0), dat: '0, cnt: RW'(m_cnt)};
         exp_q.push_back(it);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b1; w = 5; h = 5; hb = 1; vb = 1; sel = 2'd0;
      repeat (3) @(negedge clk);
      checks++; if (sif.fval !== 1'b0) begin errors++; $display("FAIL reset_fval got %b want 0", sif.fval); end
      checks++; if (sif.lval !== 1'b0) begin errors++; $display("FAIL reset_lval got %b want 0", sif.lval); end
      checks++; if (sif.pix_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", sif.pix_data); end
      checks++; if (sif.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", sif.frame_done); end
      checks++; if (sif.frame_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", sif.frame_cnt); end
      rst = 1'b0; en = 1'b0;
   endtask

   // 64x64 PIX_INC frame; enable drops after line 10 and width changes mid-frame.
   task automatic test_spec_frame();
      int cyc = 0, ff = -1, fl = -1, pulses = 0, run = 0, bad_len = 0;
      int dones = 0, frises = 0;
      logic pf = 1'b0, pl = 1'b0;
      logic [DW*CH-1:0] last_dat = '0;
      do_reset();
      w = 64; h = 64; hb = 10; vb = 20; sel = 2'd0; en = 1'b1;
      repeat (5400) begin
         @(negedge clk);
         cyc++;
         if (sif.fval && !pf) frises++;
         if (sif.fval && ff < 0) ff = cyc;
         if (sif.lval && fl < 0) fl = cyc;
         if (sif.lval) begin run++; last_dat = sif.pix_data; end
         if (!sif.lval && pl) begin
            pulses++;
            if (run != 64) bad_len++;
            run = 0;
         end
         if (sif.frame_done) dones++;
         if (pulses == 10) en = 1'b0;
         if (pulses == 20) w = 32;
         pf = sif.fval; pl = sif.lval;
      end
      checks++; if (fl - ff !== GAP) begin errors++; $display("FAIL spec_gap got %0d want %0d", fl - ff, GAP); end
      checks++; if (pulses !== 64) begin errors++; $display("FAIL spec_lines got %0d want 64", pulses); end
      checks++; if (bad_len !== 0) begin errors++; $display("FAIL spec_line_len got %0d bad lines want 0", bad_len); end
      checks++; if (last_dat[3*DW +: DW] !== 10'd255) begin errors++; $display("FAIL spec_last_ch3 got %0d want 255", last_dat[3*DW +: DW]); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL spec_done got %0d want 1", dones); end
      checks++; if (sif.frame_cnt !== 32'd1) begin errors++; $display("FAIL spec_cnt got %0d want 1", sif.frame_cnt); end
      checks++; if (frises !== 1 || sif.fval !== 1'b0) begin errors++; $display("FAIL spec_idle got rises %0d fval %b want 1 and 0", frises, sif.fval); end
   endtask

   task automatic test_lfsr_first();
      int guard = 0;
      logic [DW-1:0] e0, e1;
      do_reset();
      w = 4; h = 1; hb = 1; vb = 1; sel = 2'd3; en = 1'b1;
      @(negedge clk);
      while (!sif.lval && guard < 20) begin
         checks++; if (sif.pix_data !== '0) begin errors++; $display("FAIL lfsr_blank_data got %h want 0", sif.pix_data); end
         @(negedge clk); guard++;
      end
`ifdef SENSOR_STREAM_GEN_FRAME_TAG_EN
      e0 = '0; e1 = '0;
`else
      e0 = 10'h0E1; e1 = 10'h0E0;
`endif
      checks++; if (sif.lval !== 1'b1) begin errors++; $display("FAIL lfsr_lval_timeout got %b want 1", sif.lval); end
      checks++; if (sif.pix_data[DW-1:0] !== e0) begin errors++; $display("FAIL lfsr_ch0 got %h want %h", sif.pix_data[DW-1:0], e0); end
      checks++; if (sif.pix_data[2*DW-1:DW] !== e1) begin errors++; $display("FAIL lfsr_ch1 got %h want %h", sif.pix_data[2*DW-1:DW], e1); end
      en = 1'b0;
   endtask

   // Random frame chain with garbage config applied between latch points.
   task automatic test_random_frames();
      int cw[NFR], chh[NFR], chb[NFR], cvb[NFR], cs[NFR];
      item_t it, idle;
      int n;
      do_reset();
      exp_q.delete();
      m_lfsr = 16'hACE1; m_cnt = 0;
      for (int f = 0; f < NFR; f++) begin
         cw[f]  = (f == 0) ? 0 : $urandom_range(0, 6);
         chh[f] = (f == 0) ? 0 : $urandom_range(0, 4);
         chb[f] = (f == 0) ? 0 : $urandom_range(0, 3);
         cvb[f] = (f == 0) ? 0 : $urandom_range(0, 3);
         cs[f]  = (f == 0) ? 0 : $urandom_range(0, 3);
         fstart[f] = exp_q.size();
         model_frame(cw[f], chh[f], chb[f], cvb[f], cs[f]);
      end
      idle = '{fval: 1'b0, lval: 1'b0, done: 1'b0, dat: '0, cnt: RW'(m_cnt)};
      for (int i = 0; i < 4; i++) exp_q.push_back(idle);
      n = exp_q.size();
      @(negedge clk);
      w = cw[0]; h = chh[0]; hb = chb[0]; vb = cvb[0]; sel = cs[0]; en = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         it = exp_q[i];
         checks++;
         if ({sif.fval, sif.lval, sif.frame_done, sif.pix_data, sif.frame_cnt} !==
             {it.fval, it.lval, it.done, it.dat, it.cnt}) begin
            errors++;
            $display("FAIL rand_cycle %0d got f%b l%b d%b %h c%0d want f%b l%b d%b %h c%0d", i,
                     sif.fval, sif.lval, sif.frame_done, sif.pix_data, sif.frame_cnt,
                     it.fval, it.lval, it.done, it.dat, it.cnt);
         end
         w = $urandom_range(0, 9); h = $urandom_range(0, 9);
         hb = $urandom_range(0, 9); vb = $urandom_range(0, 9); sel = 2'($urandom_range(0, 3));
         for (int f = 1; f < NFR; f++) begin
            if (i + 1 == fstart[f]) begin
               w = cw[f]; h = chh[f]; hb = chb[f]; vb = cvb[f]; sel = cs[f];
            end
         end
         if (i >= fstart[NFR-1]) en = 1'b0;
      end
   endtask

   task automatic test_reset_mid_line();
      int guard = 0, cyc = 0, ff = -1, fl = -1;
      do_reset();
      w = 2; h = 1; hb = 1; vb = 1; sel = 2'd0; en = 1'b1;
      @(negedge clk);
      while (!(sif.lval && sif.frame_cnt >= 1) && guard < 100) begin @(negedge clk); guard++; end
      checks++; if (guard >= 100) begin errors++; $display("FAIL midrst_timeout got %0d cycles want <100", guard); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({sif.fval, sif.lval, sif.pix_data, sif.frame_cnt} !== '0) begin
         errors++;
         $display("FAIL midrst_clear got f%b l%b %h c%0d want all 0", sif.fval, sif.lval, sif.pix_data, sif.frame_cnt);
      end
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk); cyc++;
         if (sif.fval && ff < 0) ff = cyc;
         if (sif.lval && fl < 0) fl = cyc;
      end
      checks++; if (ff !== 1 || fl - ff !== GAP) begin errors++; $display("FAIL midrst_restart got fval@%0d gap %0d want 1 and %0d", ff, fl - ff, GAP); end
      en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; w = '0; h = '0; hb = '0; vb = '0; sel = '0;
      test_reset();
      test_spec_frame();
      test_lfsr_first();
      test_random_frames();
      test_random_frames();
      test_reset_mid_line();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
